// File: rtl/boid_pixel_writer.sv
// Erase-then-draw pixel writer for boid positions, with a per-boid table of last-drawn addresses.
// Define BOID_PIXEL_CROSS_EN to draw each boid as a 5-pixel plus instead of a single pixel.
module boid_pixel_writer #(
    parameter int          N_BOIDS    = 2,
    parameter int          ID_W       = $clog2(N_BOIDS) + 1,
    parameter int          FRAC_BITS  = 16,
    parameter int          SCREEN_W   = 640,
    parameter int          SCREEN_H   = 480,
    parameter int          ADDR_W     = 19,
    parameter logic [7:0]  BOID_COLOR = 8'hFF,
    parameter logic [7:0]  BG_COLOR   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ID_W-1:0]   in_id,
    input  logic [31:0]       in_x,
    input  logic [31:0]       in_y,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              id_err
);
    // state | meaning
    // IDLE  | waiting for a position update
    // CONV  | bounds check and address computation
    // ERASE | writing background over the previously drawn pixel(s)
    // DRAW  | writing boid colour at the new pixel(s)
    // UPD   | committing the new address/mask to the table
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CONV  = 3'd1;
    localparam logic [2:0] S_ERASE = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_UPD   = 3'd4;

    localparam int IDX_W = (N_BOIDS > 1) ? $clog2(N_BOIDS) : 1;
    localparam logic [ID_W:0] N_ID = (ID_W + 1)'(N_BOIDS);
`ifdef BOID_PIXEL_CROSS_EN
    localparam int MASK_W = 5;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_W);
`else
    localparam int MASK_W = 1;
`endif

    logic [2:0]               state;
    logic [IDX_W-1:0]         id_r;
    logic signed [31:0]       px_r;
    logic signed [31:0]       py_r;
    logic [ADDR_W-1:0]        new_addr_r;
    logic [MASK_W-1:0]        new_mask_r;
    logic [ADDR_W-1:0]        tbl_addr [N_BOIDS];
    logic [MASK_W-1:0]        tbl_mask [N_BOIDS];

    logic [ADDR_W-1:0]        conv_addr;
    logic [MASK_W-1:0]        conv_mask;
    logic [ADDR_W-1:0]        old_addr;
    logic [MASK_W-1:0]        old_mask;
    logic                     need_erase;
    logic                     wr_done;
    logic                     id_bad;

    function automatic logic pix_ok(input logic signed [31:0] x, input logic signed [31:0] y);
        return (x >= 0) && (x < SCREEN_W) && (y >= 0) && (y < SCREEN_H);
    endfunction

`ifdef BOID_PIXEL_CROSS_EN
    logic [2:0]        ofs;
    logic [2:0]        ofs_next;
    logic [MASK_W-1:0] act_mask;

    // Index of the first set mask bit at or above start; 5 means none left.
    function automatic logic [2:0] first_from(input logic [4:0] m, input int start);
        logic [2:0] r;
        r = 3'd5;
        for (int k = 4; k >= 0; k--)
            if (k >= start && m[k]) r = 3'(k);
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] ofs_addr(input logic [ADDR_W-1:0] c, input logic [2:0] o);
        case (o)
            3'd1:    return c - 1'b1;
            3'd2:    return c + 1'b1;
            3'd3:    return c - ROW_STEP;
            3'd4:    return c + ROW_STEP;
            default: return c;
        endcase
    endfunction

    assign act_mask = (state == S_ERASE) ? old_mask : new_mask_r;
    assign ofs_next = first_from(act_mask, int'(ofs) + 1);
`endif

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign id_bad    = ({1'b0, in_id} >= N_ID);
    assign wr_done   = wr_en && wr_ready;
    assign old_addr  = tbl_addr[id_r];
    assign old_mask  = tbl_mask[id_r];
    assign conv_addr = ADDR_W'(py_r * SCREEN_W + px_r);

    always_comb begin
        conv_mask    = '0;
        conv_mask[0] = pix_ok(px_r, py_r);
`ifdef BOID_PIXEL_CROSS_EN
        conv_mask[1] = pix_ok(px_r - 1, py_r);
        conv_mask[2] = pix_ok(px_r + 1, py_r);
        conv_mask[3] = pix_ok(px_r, py_r - 1);
        conv_mask[4] = pix_ok(px_r, py_r + 1);
`endif
    end

    // A same-address update with an identical mask leaves the old pixels to be overdrawn.
    assign need_erase = (old_mask != '0) && ((old_addr != conv_addr) || (old_mask != conv_mask));

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state == S_ERASE) begin
            wr_en   = 1'b1;
            wr_data = BG_COLOR;
`ifdef BOID_PIXEL_CROSS_EN
            wr_addr = ofs_addr(old_addr, ofs);
`else
            wr_addr = old_addr;
`endif
        end else if (state == S_DRAW) begin
            wr_en   = 1'b1;
            wr_data = BOID_COLOR;
`ifdef BOID_PIXEL_CROSS_EN
            wr_addr = ofs_addr(new_addr_r, ofs);
`else
            wr_addr = new_addr_r;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            id_r       <= '0;
            px_r       <= '0;
            py_r       <= '0;
            new_addr_r <= '0;
            new_mask_r <= '0;
            id_err     <= 1'b0;
            for (int i = 0; i < N_BOIDS; i++) begin
                tbl_addr[i] <= '0;
                tbl_mask[i] <= '0;
            end
`ifdef BOID_PIXEL_CROSS_EN
            ofs <= '0;
`endif
        end else begin
            id_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (id_bad) begin
                            id_err <= 1'b1;
                        end else begin
                            id_r  <= in_id[IDX_W-1:0];
                            px_r  <= $signed(in_x) >>> FRAC_BITS;
                            py_r  <= $signed(in_y) >>> FRAC_BITS;
                            state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    new_addr_r <= conv_addr;
                    new_mask_r <= conv_mask;
                    if (need_erase) begin
                        state <= S_ERASE;
`ifdef BOID_PIXEL_CROSS_EN
                        ofs <= first_from(old_mask, 0);
`endif
                    end else if (conv_mask != '0) begin
                        state <= S_DRAW;
`ifdef BOID_PIXEL_CROSS_EN
                        ofs <= first_from(conv_mask, 0);
`endif
                    end else begin
                        state <= S_UPD;
                    end
                end
                S_ERASE: begin
                    if (wr_done) begin
`ifdef BOID_PIXEL_CROSS_EN
                        if (ofs_next != 3'd5) begin
                            ofs <= ofs_next;
                        end else if (new_mask_r != '0) begin
                            ofs   <= first_from(new_mask_r, 0);
                            state <= S_DRAW;
                        end else begin
                            state <= S_UPD;
                        end
`else
                        state <= (new_mask_r != '0) ? S_DRAW : S_UPD;
`endif
                    end
                end
                S_DRAW: begin
                    if (wr_done) begin
`ifdef BOID_PIXEL_CROSS_EN
                        if (ofs_next != 3'd5) ofs <= ofs_next;
                        else                  state <= S_UPD;
`else
                        state <= S_UPD;
`endif
                    end
                end
                S_UPD: begin
                    tbl_addr[id_r] <= new_addr_r;
                    tbl_mask[id_r] <= new_mask_r;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boid_pixel_writer.sv
// Self-checking bench for boid_pixel_writer (single-pixel build): directed cases plus randomized updates.
module tb_boid_pixel_writer;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_id;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        wr_en;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        id_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [18:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];

    // Reference: last pixel drawn per boid, in screen coordinates.
    bit m_drawn [2];
    int m_px    [2];
    int m_py    [2];

    boid_pixel_writer dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_id    (in_id),
        .in_x     (in_x),
        .in_y     (in_y),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .id_err   (id_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after posedge, so negedge values are what the next posedge sees.
    always @(negedge clk)
        if (reset && wr_en && wr_ready) got_q.push_back('{wr_addr, wr_data});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] pix_addr(input int px, input int py);
        return 19'(py * 640 + px);
    endfunction

    // Expected framebuffer writes for one update, from the screen-level rules.
    task automatic model(input int id, input logic [31:0] x, input logic [31:0] y);
        int  px, py;
        bit  on_screen;
        px = int'($signed(x)) / 65536;
        py = int'($signed(y)) / 65536;
        if ($signed(x) < 0 && (x[15:0] != 16'h0)) px = px - 1;
        if ($signed(y) < 0 && (y[15:0] != 16'h0)) py = py - 1;
        on_screen = (px >= 0) && (px < 640) && (py >= 0) && (py < 480);
        exp_q.delete();
        if (m_drawn[id] && !(on_screen && m_px[id] == px && m_py[id] == py))
            exp_q.push_back('{pix_addr(m_px[id], m_py[id]), 8'h00});
        if (on_screen)
            exp_q.push_back('{pix_addr(px, py), 8'hFF});
        m_drawn[id] = on_screen;
        m_px[id]    = px;
        m_py[id]    = py;
    endtask

    task automatic send(input int id, input logic [31:0] x, input logic [31:0] y, output int edges);
        in_id    = 2'(id);
        in_x     = x;
        in_y     = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        edges    = 0;
        while (!in_ready && edges < 60) begin
            step();
            edges++;
        end
    endtask

    task automatic do_update(input string tag, input int id, input logic [31:0] x, input logic [31:0] y);
        int edges;
        model(id, x, y);
        got_q.delete();
        send(id, x, y, edges);
        check({tag, "_latency"}, 32'(edges), 32'(2 + exp_q.size()));
        check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_addr"}, 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check({tag, "_data"}, 32'(got_q[i].data), 32'(exp_q[i].data));
        end
    endtask

    initial begin
        int          a_hold, d_hold, n, rpx, rpy, rid;
        logic [31:0] rx, ry;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_id    = '0;
        in_x     = '0;
        in_y     = '0;
        wr_ready = 1'b1;
        for (int i = 0; i < 2; i++) m_drawn[i] = 1'b0;
        step();
        step();
        check("rst_wr_en",    32'(wr_en),    32'd0);
        check("rst_wr_addr",  32'(wr_addr),  32'd0);
        check("rst_wr_data",  32'(wr_data),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_id_err",   32'(id_err),   32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        step();

        do_update("first_draw", 0, 32'h000A_0000, 32'h0005_0000);
        check("first_draw_addr3210", 32'(got_q.size() > 0 ? got_q[0].addr : 19'h7FFFF), 32'd3210);
        do_update("move",       0, 32'h000B_0000, 32'h0005_0000);
        do_update("exit",       0, 32'hFFFF_0000, 32'h0005_0000);
        do_update("reenter",    0, 32'h0014_8000, 32'h0007_0000);
        do_update("same_addr",  0, 32'h0014_0001, 32'h0007_FFFF);

        // Stall during DRAW for boid 1 (no previous pixel).
        model(1, 32'h0064_0000, 32'h0064_0000);
        got_q.delete();
        wr_ready = 1'b0;
        in_id    = 2'd1;
        in_x     = 32'h0064_0000;
        in_y     = 32'h0064_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("stall_busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (!wr_en && n < 10) begin
            step();
            n++;
        end
        check("stall_wr_en", 32'(wr_en), 32'd1);
        check("stall_addr",  32'(wr_addr), 32'(exp_q[0].addr));
        check("stall_data",  32'(wr_data), 32'hFF);
        a_hold = int'(wr_addr);
        d_hold = int'(wr_data);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_en",   32'(wr_en),   32'd1);
            check("stall_hold_addr", 32'(wr_addr), 32'(a_hold));
            check("stall_hold_data", 32'(wr_data), 32'(d_hold));
            check("stall_hold_busy", 32'(busy),    32'd1);
        end
        wr_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check("stall_ready_back", 32'(in_ready), 32'd1);
        check("stall_one_write",  32'(got_q.size()), 32'd1);

        // Out-of-range id is dropped with a single id_err pulse.
        got_q.delete();
        in_id    = 2'd2;
        in_x     = 32'h0001_0000;
        in_y     = 32'h0001_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("bad_id_err_pulse", 32'(id_err),   32'd1);
        check("bad_id_ready",     32'(in_ready), 32'd1);
        check("bad_id_no_wr",     32'(wr_en),    32'd0);
        step();
        check("bad_id_err_clear", 32'(id_err),   32'd0);
        step();
        check("bad_id_nwrites",   32'(got_q.size()), 32'd0);
        do_update("after_bad_id", 1, 32'h0065_0000, 32'h0064_0000);

        // Randomized updates, some repeating the previous position of the boid.
        for (int t = 0; t < 40; t++) begin
            rid = int'($urandom_range(0, 1));
            if (m_drawn[rid] && $urandom_range(0, 4) == 0) begin
                rpx = m_px[rid];
                rpy = m_py[rid];
            end else begin
                rpx = int'($urandom_range(0, 680)) - 20;
                rpy = int'($urandom_range(0, 520)) - 20;
            end
            rx = {16'(rpx), 16'($urandom)};
            ry = {16'(rpy), 16'($urandom)};
            do_update("random", rid, rx, ry);
        end

        // Reset while an erase is stalled.
        do_update("pre_reset", 0, 32'h0032_0000, 32'h0032_0000);
        wr_ready = 1'b0;
        in_id    = 2'd0;
        in_x     = 32'h0033_0000;
        in_y     = 32'h0032_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!wr_en && n < 10) begin
            step();
            n++;
        end
        check("mid_erase_data", 32'(wr_data), 32'h00);
        check("mid_erase_addr", 32'(wr_addr), 32'(pix_addr(50, 50)));
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_wr_en",    32'(wr_en),    32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_busy",     32'(busy),     32'd0);
        step();
        reset    = 1'b1;
        wr_ready = 1'b1;
        for (int i = 0; i < 2; i++) m_drawn[i] = 1'b0;
        step();
        do_update("post_reset", 0, 32'h0033_0000, 32'h0032_0000);
        check("post_reset_no_erase", 32'(got_q.size()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/boid_pixel_writer.md
Name: boid_pixel_writer

Overview:
- Downstream of the boid accelerator controller/datapath. Consumes each boid's updated fixed-point position (x, y) as it is written back.
- Erases the boid's previously drawn pixel and draws the new one in the M10K VGA framebuffer.
- Keeps a per-boid table of last-drawn pixel addresses so the frame never needs a full clear.

Parameters:
- N_BOIDS, 2, number of boids tracked; sizes the address table.
- ID_W, $clog2(N_BOIDS)+1, width of the boid index; matches the controller's which_boid.
- FRAC_BITS, 16, fractional bits of in_x/in_y; pixel = value >>> FRAC_BITS.
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- ADDR_W, 19, framebuffer address width.
- BOID_COLOR, 8'hFF, pixel value written when drawing.
- BG_COLOR, 8'h00, pixel value written when erasing.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  position update offered
- in_ready  out  1  block accepts an update this cycle
- in_id  in  ID_W  boid index
- in_x  in  32  signed fixed-point x position
- in_y  in  32  signed fixed-point y position
- wr_en  out  1  framebuffer write request
- wr_ready  in  1  framebuffer accepts write this cycle
- wr_addr  out  ADDR_W  pixel address, y*SCREEN_W + x
- wr_data  out  8  pixel colour
- busy  out  1  high whenever state != IDLE
- id_err  out  1  one-cycle pulse when an out-of-range id is dropped

Behaviour:
- Reset: async assert when reset==0.
  - State goes to IDLE; every table entry's valid bit clears.
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, busy=0, id_err=0, in_ready=1.
- Handshake: an update is accepted on the rising edge where in_valid && in_ready. in_ready is 1 only in IDLE.
- Write handshake: a write completes on the edge where wr_en && wr_ready. While wr_ready==0, wr_en, wr_addr and wr_data hold stable.
- State machine:
  - IDLE. On accept, register id, px = in_x>>>FRAC_BITS and py = in_y>>>FRAC_BITS (arithmetic shift), then go to CONV.
    - If in_id >= N_BOIDS: pulse id_err, stay in IDLE, no writes.
  - CONV (1 cycle).
    - in_bounds = 0<=px<SCREEN_W && 0<=py<SCREEN_H, with px/py treated as signed.
    - new_addr = py*SCREEN_W+px, truncated to ADDR_W.
    - Go to ERASE if the old entry is valid and (old_addr != new_addr or !in_bounds).
    - Otherwise go to DRAW if in_bounds, or to UPD if not.
  - ERASE. wr_en=1, wr_addr=old_addr, wr_data=BG_COLOR. On write completion, go to DRAW if in_bounds, else UPD.
  - DRAW. wr_en=1, wr_addr=new_addr, wr_data=BOID_COLOR. On completion, go to UPD.
  - UPD (1 cycle). Table[id] becomes {valid=in_bounds, addr=new_addr}. Go to IDLE.
- Same-address update: the erase is skipped, but the pixel is still redrawn in DRAW.
- Latency with wr_ready held at 1:
  - Accept at edge 0; ERASE write at edge 2; DRAW write at edge 3; in_ready high again after edge 4.
  - When ERASE is skipped, each later step moves one edge earlier.
- Out-of-bounds update: the old pixel is erased and the entry is invalidated. No draw.
- Boids are independent. Updates to different ids never write each other's addresses.
- Reset mid-operation: any pending write is abandoned. The table is cleared, so pixels already drawn stay on screen; the framebuffer owner clears the framebuffer after reset.

Optional Feature:
- Macro: BOID_PIXEL_CROSS_EN.
- Defined:
  - Each boid is a 5-pixel plus: centre, then (x-1,y), (x+1,y), (x,y-1), (x,y+1).
  - ERASE and DRAW each step a 3-bit offset counter through the 5 offsets in that order.
  - Each offset pixel is clip-checked on its own; out-of-bounds offsets are skipped with no write and no extra cycle.
  - The table stores the centre address plus a 5-bit per-offset valid mask.
  - The same-address erase skip applies only when the centre and the mask are identical.
- Undefined: single-pixel behaviour exactly as above, with no offset counter or mask logic.

Test Plan:
- First draw: id 0, x=0x000A_0000, y=0x0005_0000 → no erase; one write addr=3210, data=FF; in_ready high 3 edges after accept.
- Move: id 0, x=0x000B_0000, y=0x0005_0000 → write addr 3210 data 00, then addr 3211 data FF, on consecutive edges.
- Exit the screen: id 0, x=0xFFFF_0000 (-1) → erase at 3211, no draw. A later in-bounds update for id 0 performs no erase.
- Stall: wr_ready=0 for 3 cycles during DRAW → wr_en/wr_addr/wr_data stable through the stall; exactly one completed write; busy high throughout.
- Bad id: N_BOIDS=2, in_id=2 → id_err pulses for 1 cycle, no wr_en, table unchanged.
- Reset mid-ERASE: assert reset=0 asynchronously → wr_en drops immediately, in_ready=1. The next update for that id performs no erase.
